fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the instruction memory and the IF stage of the 5-stage pipeline. It owns the single instruction-memory port and shares it between a program loader (load handshake) and instruction fetch. It maintains the PC (byte address, step 2) and fills the IF/ID register, honouring stall, redirect (branch/jump) and halt requests from later stages.

Parameters:
N, 16, instruction memory depth in entries; memory is indexed directly by byte address, so valid PCs are 0..N-1.
RESET_PC, 16'h0000, PC value loaded on reset and on start.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse: IDLE/HALT -> RUN, PC <= RESET_PC
load_valid  input  1  loader presents a word
load_addr  input  16  loader target address
load_data  input  16  loader instruction word
load_last  input  1  qualifies final load word
load_ready  output  1  sequencer accepts a load word this cycle
imem_addr  output  16  memory address (mux: load_addr or pc)
imem_we  output  1  memory write enable
imem_wdata  output  16  memory write data
imem_rdata  input  16  combinational read data at imem_addr
stall  input  1  hazard unit: hold PC and IF/ID
redirect_valid  input  1  taken branch/jump
redirect_pc  input  16  redirect target
halt  input  1  stop fetching
if_id_instr  output  16  IF/ID instruction
if_id_pc  output  16  IF/ID PC of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
state  output  2  IDLE=0, LOAD=1, RUN=2, HALT=3
pc  output  16  current fetch PC

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0. Reset mid-load or mid-run discards all progress and writes nothing on that cycle.
- load_ready = 1 in IDLE and LOAD, 0 in RUN and HALT. Arbitration: fetch owns the port in RUN/HALT; the loader owns it otherwise.
- imem_we = load_valid & load_ready & (load_addr < N); imem_addr = load_addr when load_ready, else pc. Out-of-range load words are accepted and dropped.
- IDLE: load_valid -> LOAD (the first word is written in this same cycle). start -> RUN, pc<=RESET_PC. If start and load_valid are both high, the load wins and start is ignored.
- LOAD: each accepted word is written. A handshake with load_last=1 -> IDLE. start is ignored in LOAD.
- RUN, per cycle, in priority order:
  1. halt: -> HALT, if_id_valid<=0.
  2. redirect_valid: pc<=redirect_pc, if_id_valid<=0 (flush). This overrides stall.
  3. stall: pc, if_id_* hold.
  4. pc >= N: -> HALT, if_id_valid<=0.
  5. Else: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+2.
- PC arithmetic is 16-bit and wraps modulo 2^16. An odd redirect_pc is used as-is.
- Fetch latency: the instruction at address A appears on if_id_* one cycle after the cycle in which pc=A.
- HALT: if_id_valid=0, pc holds. start -> RUN, pc<=RESET_PC. Loads are refused.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0. fetch_cnt increments on each RUN case-5 cycle; stall_cnt increments on each RUN case-3 cycle. Both saturate at 16'hFFFF and clear on start.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load 16'h1010@0, 16'h6002@2 (last), then start: cycles after start give if_id {pc=0, instr=1010, valid=1}, then {pc=2, instr=6002, valid=1}; pc=4.
- In RUN, assert stall for 3 cycles at pc=4: pc stays 4, if_id unchanged, load_ready=0 throughout.
- At pc=6, assert redirect_valid with redirect_pc=16'h000E and stall=1 together: next cycle pc=E, if_id_valid=0; following cycle if_id_pc=E.
- With N=16, run from 0 with no stalls until pc=16: at that edge state=HALT, if_id_valid=0, pc=16; then start -> RUN with pc=0.
- Assert rst during LOAD with load_valid=1 and load_addr=4: no write that cycle, state=IDLE, pc=0, all if_id outputs=0.
- With FETCH_PERF_CNT_EN: 4 fetches plus 2 stalls -> fetch_cnt=4, stall_cnt=2; a following start clears both to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// IF stage and instruction-memory arbiter: shares the single memory port between the loader and fetch.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_cnt/stall_cnt performance counters.
module fetch_sequencer #(
  parameter int          N        = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic [15:0] imem_addr,
  output logic        imem_we,
  output logic [15:0] imem_wdata,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic [1:0]  state,
  output logic [15:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [16:0] LIMIT = 17'(N);

  state_t st;
  logic   addr_ok;
  logic   pc_end;
  logic   start_go;

  assign state      = st;
  assign load_ready = (st == IDLE) || (st == LOAD);
  assign addr_ok    = {1'b0, load_addr} < LIMIT;
  assign pc_end     = {1'b0, pc} >= LIMIT;

  // The loader owns the port whenever it may be accepted; a reset cycle must never write.
  assign imem_addr  = load_ready ? load_addr : pc;
  assign imem_we    = load_valid && load_ready && addr_ok && !rst;
  assign imem_wdata = load_data;

  assign start_go = start && (((st == IDLE) && !load_valid) || (st == HALT));

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (load_valid) begin
            st <= LOAD;
          end else if (start) begin
            st <= RUN;
            pc <= RESET_PC;
          end
        end
        LOAD: begin
          if (load_valid && load_last) st <= IDLE;
        end
        RUN: begin
          // Priority: halt, redirect (beats stall), stall, end of memory, fetch.
          if (halt) begin
            st          <= HALT;
            if_id_valid <= 1'b0;
          end else if (redirect_valid) begin
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            if (pc_end) begin
              st          <= HALT;
              if_id_valid <= 1'b0;
            end else begin
              if_id_instr <= imem_rdata;
              if_id_pc    <= pc;
              if_id_valid <= 1'b1;
              pc          <= pc + 16'd2;
            end
          end
        end
        HALT: begin
          if_id_valid <= 1'b0;
          if (start) begin
            st <= RUN;
            pc <= RESET_PC;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic do_fetch;
  logic do_stall;

  assign do_stall = (st == RUN) && !halt && !redirect_valid && stall;
  assign do_fetch = (st == RUN) && !halt && !redirect_valid && !stall && !pc_end;

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (do_fetch && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
      if (do_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  logic unused_start_go;
  assign unused_start_go = start_go;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed steps plus randomized traffic against a reference model.
module tb_fetch_sequencer;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, start, load_valid, load_last, stall, redirect_valid, halt;
  logic [15:0] load_addr, load_data, redirect_pc;
  logic        load_ready, imem_we, if_id_valid;
  logic [15:0] imem_addr, imem_wdata, imem_rdata, if_id_instr, if_id_pc, pc;
  logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  logic [15:0] mem [N] = '{default: 16'h0000};

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state only.
  int          m_state;
  logic [15:0] m_pc, m_instr, m_ipc;
  logic        m_valid;
  logic        m_known = 1'b0;
  logic [15:0] m_mem [N] = '{default: 16'h0000};
  int          m_fc = 0;
  int          m_sc = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_we && (imem_addr < 16'(N))) mem[imem_addr[3:0]] <= imem_wdata;

  assign imem_rdata = (imem_addr < 16'(N)) ? mem[imem_addr[3:0]] : 16'h0000;

  fetch_sequencer #(.N(N), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .state(state), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks port mux/handshake before the edge and all registers after it.
  task automatic applyStimulus(input logic r, input logic s, input logic lv, input logic [15:0] la,
                               input logic [15:0] ld, input logic ll, input logic stl,
                               input logic rv, input logic [15:0] rp, input logic h);
    int          n_state;
    logic [15:0] n_pc, n_instr, n_ipc;
    logic        n_valid, ready, we, go;
    rst = r; start = s; load_valid = lv; load_addr = la; load_data = ld; load_last = ll;
    stall = stl; redirect_valid = rv; redirect_pc = rp; halt = h;
    #1;
    ready = (m_state == 0) || (m_state == 1);
    we    = !r && lv && ready && (int'(la) < N);
    if (m_known) begin
      checkOutput("load_ready", 16'(load_ready), 16'(ready));
      checkOutput("imem_we", 16'(imem_we), 16'(we));
      checkOutput("imem_addr", imem_addr, ready ? la : m_pc);
      if (we) checkOutput("imem_wdata", imem_wdata, ld);
    end
    n_state = m_state; n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc; n_valid = m_valid;
    go = 1'b0;
    if (r) begin
      n_state = 0; n_pc = 16'h0; n_instr = 16'h0; n_ipc = 16'h0; n_valid = 1'b0;
    end else if (m_state == 0) begin
      if (lv) n_state = 1;
      else if (s) begin n_state = 2; n_pc = 16'h0; go = 1'b1; end
    end else if (m_state == 1) begin
      if (lv && ll) n_state = 0;
    end else if (m_state == 2) begin
      if (h) begin n_state = 3; n_valid = 1'b0; end
      else if (rv) begin n_pc = rp; n_valid = 1'b0; end
      else if (stl) begin if (m_sc < 65535) m_sc++; end
      else if (int'(m_pc) >= N) begin n_state = 3; n_valid = 1'b0; end
      else begin
        n_instr = m_mem[int'(m_pc)]; n_ipc = m_pc; n_valid = 1'b1; n_pc = m_pc + 16'd2;
        if (m_fc < 65535) m_fc++;
      end
    end else begin
      n_valid = 1'b0;
      if (s) begin n_state = 2; n_pc = 16'h0; go = 1'b1; end
    end
    if (r || go) begin m_fc = 0; m_sc = 0; end
    @(posedge clk);
    #1;
    if (we) m_mem[int'(la)] = ld;
    m_state = n_state; m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_valid = n_valid;
    if (r) m_known = 1'b1;
    if (m_known) begin
      checkOutput("state", 16'(state), 16'(m_state));
      checkOutput("pc", pc, m_pc);
      checkOutput("if_id_valid", 16'(if_id_valid), 16'(m_valid));
      checkOutput("if_id_pc", if_id_pc, m_ipc);
      checkOutput("if_id_instr", if_id_instr, m_instr);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("fetch_cnt", fetch_cnt, 16'(m_fc));
      checkOutput("stall_cnt", stall_cnt, 16'(m_sc));
`endif
    end
    @(negedge clk);
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    logic        r, s, lv, ll, stl, rv, h;
    logic [15:0] la, ld, rp;
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    m_state = 0; m_pc = '0; m_instr = '0; m_ipc = '0; m_valid = 1'b0;
    @(negedge clk);

    $display("[TB] reset and load");
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    checkOutput("rst_state", 16'(state), 16'd0);
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_valid", 16'(if_id_valid), 16'd0);
    applyStimulus(0, 0, 1, 16'h0000, 16'h1010, 0, 0, 0, 16'h0, 0);
    checkOutput("load_state", 16'(state), 16'd1);
    applyStimulus(0, 0, 1, 16'h0002, 16'h6002, 1, 0, 0, 16'h0, 0);
    checkOutput("load_done", 16'(state), 16'd0);

    $display("[TB] start and fetch");
    applyStimulus(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    checkOutput("start_state", 16'(state), 16'd2);
    nop();
    checkOutput("f0_pc", if_id_pc, 16'h0000);
    checkOutput("f0_instr", if_id_instr, 16'h1010);
    checkOutput("f0_valid", 16'(if_id_valid), 16'd1);
    nop();
    checkOutput("f1_pc", if_id_pc, 16'h0002);
    checkOutput("f1_instr", if_id_instr, 16'h6002);
    checkOutput("f1_nextpc", pc, 16'h0004);

    $display("[TB] stall and redirect");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0, 0);
      checkOutput("stall_pc", pc, 16'h0004);
      checkOutput("stall_ifid_pc", if_id_pc, 16'h0002);
      checkOutput("stall_ready", 16'(load_ready), 16'd0);
    end
    nop();
    checkOutput("pc6", pc, 16'h0006);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 1, 1, 16'h000E, 0);
    checkOutput("redir_pc", pc, 16'h000E);
    checkOutput("redir_flush", 16'(if_id_valid), 16'd0);
    nop();
    checkOutput("redir_ifid_pc", if_id_pc, 16'h000E);
    checkOutput("redir_valid", 16'(if_id_valid), 16'd1);
    nop();
    checkOutput("end_state", 16'(state), 16'd3);
    checkOutput("end_pc", pc, 16'h0010);

    $display("[TB] run to end of memory");
    applyStimulus(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    checkOutput("restart_pc", pc, 16'h0000);
    for (int i = 0; i < 8; i++) nop();
    checkOutput("run_pc16", pc, 16'h0010);
    nop();
    checkOutput("halt_state", 16'(state), 16'd3);
    checkOutput("halt_valid", 16'(if_id_valid), 16'd0);
    checkOutput("halt_pc", pc, 16'h0010);

    $display("[TB] reset during load");
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    applyStimulus(0, 0, 1, 16'h0008, 16'h1234, 0, 0, 0, 16'h0, 0);
    applyStimulus(1, 0, 1, 16'h0004, 16'hBEEF, 0, 0, 0, 16'h0, 0);
    checkOutput("rl_state", 16'(state), 16'd0);
    checkOutput("rl_pc", pc, 16'h0000);
    checkOutput("rl_instr", if_id_instr, 16'h0000);
    checkOutput("rl_ifid_pc", if_id_pc, 16'h0000);
    checkOutput("rl_mem4", mem[4], 16'h0000);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 11) == 0);
      lv  = (m_state <= 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      la  = 16'($urandom_range(0, 19));
      ld  = 16'($urandom);
      ll  = (m_state == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      stl = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      h   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: rp = 16'(2 * $urandom_range(0, 9));
        1: rp = 16'(2 * $urandom_range(0, 7) + 1);
        2: rp = 16'hFFFE;
        default: rp = 16'hFFFF;
      endcase
      applyStimulus(r, s, lv, la, ld, ll, stl, rv, rp, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
